decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: small input FIFO, field/class decode with branch-target
// precompute, registered valid/ready output, and a HALT state that only reset leaves.

package opcode_pkg;
    localparam logic [7:0] OP_NOP             = 8'h00;
    localparam logic [7:0] OP_ADD             = 8'h30;
    localparam logic [7:0] OP_SUB             = 8'h31;
    localparam logic [7:0] OP_AND             = 8'h32;
    localparam logic [7:0] OP_OR              = 8'h33;
    localparam logic [7:0] OP_XOR             = 8'h34;
    localparam logic [7:0] OP_SHL             = 8'h35;
    localparam logic [7:0] OP_SHR             = 8'h36;
    localparam logic [7:0] OP_ADDI            = 8'h37;
    localparam logic [7:0] OP_LOAD            = 8'h40;
    localparam logic [7:0] OP_LOAD_RESTORE_PC = 8'h41;
    localparam logic [7:0] OP_STORE           = 8'h50;
    localparam logic [7:0] OP_JMP_ALWAYS      = 8'h60;
    localparam logic [7:0] OP_JMP_ZERO        = 8'h61;
    localparam logic [7:0] OP_JMP_NZ          = 8'h62;
    localparam logic [7:0] OP_HALT            = 8'hFF;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_NOP     = 3'd5,
        CLS_ILLEGAL = 3'd7
    } insn_class_e;
endpackage

package decode_stage_pkg;
    import opcode_pkg::*;

    typedef struct packed {
        logic [63:0] exec_mask;
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_pkt_t;

    typedef struct packed {
        logic [63:0] exec_mask;
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        insn_class_e cls;
        logic        flow_change;
        logic [31:0] branch_target;
    } dec_pkt_t;
endpackage

module decode_stage
    import opcode_pkg::*;
    import decode_stage_pkg::*;
#(
    parameter int          CORE_ID    = 0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_exec_mask,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_insn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_exec_mask,
    output logic [31:0] out_pc,
    output logic [7:0]  out_opcode,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [2:0]  out_class,
    output logic        out_flow_change,
    output logic [31:0] out_branch_target,
    output logic        halted,
    output logic        illegal_seen,
    output logic [31:0] decoded_count
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CORE_ID < 0)
    begin : g_param_check
        $error("decode_stage: FIFO_DEPTH must be a power of two in 2..8");
    end

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    function automatic insn_class_e classify(input logic [7:0] op);
        insn_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_ADDI:   c = CLS_ALU;
            OP_LOAD, OP_LOAD_RESTORE_PC:       c = CLS_LOAD;
            OP_STORE:                          c = CLS_STORE;
            OP_JMP_ALWAYS, OP_JMP_ZERO,
            OP_JMP_NZ:                         c = CLS_BRANCH;
            OP_HALT:                           c = CLS_HALT;
            OP_NOP:                            c = CLS_NOP;
            default:                           c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic dec_pkt_t decode(input fetch_pkt_t p);
        dec_pkt_t d;
        d.exec_mask     = p.exec_mask;
        d.pc            = p.pc;
        d.opcode        = p.insn[7:0];
        d.rd            = p.insn[11:8];
        d.rs1           = p.insn[15:12];
        d.rs2           = p.insn[19:16];
        d.imm           = {{20{p.insn[31]}}, p.insn[31:20]};
        d.cls           = classify(p.insn[7:0]);
        d.flow_change   = (p.insn[7:0] == OP_HALT) || (p.insn[7:0] == OP_LOAD_RESTORE_PC) ||
                          (p.insn[7:0] == OP_JMP_ALWAYS) || (p.insn[7:0] == OP_JMP_ZERO) ||
                          (p.insn[7:0] == OP_JMP_NZ);
        d.branch_target = p.pc + {d.imm[29:0], 2'b00};
        return d;
    endfunction

    fetch_pkt_t     mem_q [FIFO_DEPTH];
    state_e         state_q, state_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           out_valid_q, out_valid_d;
    dec_pkt_t       out_pkt_q, out_pkt_d;
    logic           illegal_seen_q, illegal_seen_d;
    logic [31:0]    decoded_count_q, decoded_count_d;

    fetch_pkt_t     in_pkt;
    dec_pkt_t       head_dec;
    logic           fifo_empty, fifo_full, fifo_wr, out_hs, out_load;

    assign in_pkt     = {in_exec_mask, in_pc, in_insn};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Gated by reset_n so fetch sees no ready while reset is held.
    assign in_ready   = reset_n && (state_q == ST_RUN) && !fifo_full;
    assign fifo_wr    = in_valid && in_ready;
    assign out_hs     = out_valid_q && out_ready;
    assign out_load   = !fifo_empty && (!out_valid_q || out_ready) && (state_q == ST_RUN);
    assign head_dec   = decode(mem_q[rd_ptr_q[PTR_W-1:0]]);

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        out_valid_d     = out_valid_q;
        out_pkt_d       = out_pkt_q;
        illegal_seen_d  = illegal_seen_q;
        decoded_count_d = decoded_count_q;

        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (out_hs) begin
            decoded_count_d = decoded_count_q + 32'd1;
            out_valid_d     = 1'b0;
        end
        if (out_load) begin
            out_valid_d = 1'b1;
            out_pkt_d   = head_dec;
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            if (head_dec.cls == CLS_ILLEGAL) begin
                illegal_seen_d = 1'b1;
            end
            // HALT discards everything queued behind it, including a same-cycle write.
            if (head_dec.cls == CLS_HALT) begin
                state_d  = ST_HALTED;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_RUN;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            out_pkt_q       <= '0;
            illegal_seen_q  <= 1'b0;
            decoded_count_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            out_valid_q     <= out_valid_d;
            out_pkt_q       <= out_pkt_d;
            illegal_seen_q  <= illegal_seen_d;
            decoded_count_q <= decoded_count_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= in_pkt;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_exec_mask     = out_pkt_q.exec_mask;
    assign out_pc            = out_pkt_q.pc;
    assign out_opcode        = out_pkt_q.opcode;
    assign out_rd            = out_pkt_q.rd;
    assign out_rs1           = out_pkt_q.rs1;
    assign out_rs2           = out_pkt_q.rs2;
    assign out_imm           = out_pkt_q.imm;
    assign out_class         = out_pkt_q.cls;
    assign out_flow_change   = out_pkt_q.flow_change;
    assign out_branch_target = out_pkt_q.branch_target;
    assign halted            = (state_q == ST_HALTED);
    assign illegal_seen      = illegal_seen_q;
    assign decoded_count     = decoded_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default FIFO_DEPTH = 2).

module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_exec_mask;
    logic [31:0] in_pc;
    logic [31:0] in_insn;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_exec_mask;
    logic [31:0] out_pc;
    logic [7:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [31:0] out_imm;
    logic [2:0]  out_class;
    logic        out_flow_change;
    logic [31:0] out_branch_target;
    logic        halted;
    logic        illegal_seen;
    logic [31:0] decoded_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_count = 32'd0;

    decode_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exec_mask(in_exec_mask), .in_pc(in_pc), .in_insn(in_insn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exec_mask(out_exec_mask), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_class(out_class), .out_flow_change(out_flow_change),
        .out_branch_target(out_branch_target), .halted(halted),
        .illegal_seen(illegal_seen), .decoded_count(decoded_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until an accepting edge or a 20-cycle budget expires.
    task automatic send(input logic [63:0] mask, input logic [31:0] pc,
                        input logic [31:0] insn, output bit ok);
        bit acc;
        ok           = 1'b0;
        in_valid     = 1'b1;
        in_exec_mask = mask;
        in_pc        = pc;
        in_insn      = insn;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_exec_mask = '0; in_pc = '0; in_insn = '0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", halted); else n_pass++;
        n_checks++; if (decoded_count !== 32'd0) $display("FAIL rst_count got %h exp 0", decoded_count); else n_pass++;
        n_checks++; if (out_pc !== 32'd0) $display("FAIL rst_out_pc got %h exp 0", out_pc); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_add();
        bit ok;
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 32'h100, 32'hFFF2_1330, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL add_accept got %b exp 1", ok); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_lat1 got %b exp 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL add_lat2 got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_opcode !== 8'h30) $display("FAIL add_opcode got %h exp 30", out_opcode); else n_pass++;
        n_checks++; if (out_rd !== 4'd3) $display("FAIL add_rd got %h exp 3", out_rd); else n_pass++;
        n_checks++; if (out_rs1 !== 4'd1) $display("FAIL add_rs1 got %h exp 1", out_rs1); else n_pass++;
        n_checks++; if (out_rs2 !== 4'd2) $display("FAIL add_rs2 got %h exp 2", out_rs2); else n_pass++;
        n_checks++; if (out_imm !== 32'hFFFF_FFFF) $display("FAIL add_imm got %h exp ffffffff", out_imm); else n_pass++;
        n_checks++; if (out_class !== 3'd0) $display("FAIL add_class got %0d exp 0", out_class); else n_pass++;
        n_checks++; if (out_flow_change !== 1'b0) $display("FAIL add_flow got %b exp 0", out_flow_change); else n_pass++;
        n_checks++; if (out_pc !== 32'h100) $display("FAIL add_pc got %h exp 100", out_pc); else n_pass++;
        n_checks++; if (out_exec_mask !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL add_mask got %h", out_exec_mask); else n_pass++;
        n_checks++; if (out_branch_target !== 32'h0000_00FC) $display("FAIL add_target got %h exp fc", out_branch_target); else n_pass++;
        tick();
        exp_count = 32'd1;
        n_checks++; if (decoded_count !== exp_count) $display("FAIL add_count got %0d exp %0d", decoded_count, exp_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_drain got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_branch();
        bit ok;
        out_ready = 1'b1;
        send(64'h1, 32'h40, 32'h0040_0060, ok);
        tick();
        n_checks++; if (out_branch_target !== 32'h50) $display("FAIL jmp_fwd_target got %h exp 50", out_branch_target); else n_pass++;
        n_checks++; if (out_class !== 3'd3) $display("FAIL jmp_fwd_class got %0d exp 3", out_class); else n_pass++;
        n_checks++; if (out_flow_change !== 1'b1) $display("FAIL jmp_fwd_flow got %b exp 1", out_flow_change); else n_pass++;
        send(64'h1, 32'h40, 32'hFFF0_0060, ok);
        tick();
        n_checks++; if (out_branch_target !== 32'h3C) $display("FAIL jmp_back_target got %h exp 3c", out_branch_target); else n_pass++;
        n_checks++; if (out_imm !== 32'hFFFF_FFFF) $display("FAIL jmp_back_imm got %h exp ffffffff", out_imm); else n_pass++;
        tick();
        exp_count += 32'd2;
    endtask

    task automatic test_class_table();
        logic [31:0] insns [5] = '{32'h0000_0040, 32'h0000_0041, 32'h0000_0050, 32'h0000_0000, 32'h0000_0061};
        logic [2:0]  cls   [5] = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd3};
        logic        flow  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(64'h2, 32'h80, insns[i], ok);
            tick();
            n_checks++; if (out_class !== cls[i]) $display("FAIL class_tbl%0d got %0d exp %0d", i, out_class, cls[i]); else n_pass++;
            n_checks++; if (out_flow_change !== flow[i]) $display("FAIL flow_tbl%0d got %b exp %b", i, out_flow_change, flow[i]); else n_pass++;
        end
        tick();
        exp_count += 32'd5;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_pc    = 32'(32'h300 + 4 * i);
                in_insn  = 32'(32'h30 | (i << 8));
                n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, in_ready); else n_pass++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                n_checks++; if (out_pc !== 32'(32'h300 + 4 * (i - 1)) || out_valid !== 1'b1)
                    $display("FAIL b2b_out%0d got pc %h v %b exp pc %h v 1", i - 1, out_pc, out_valid, 32'(32'h300 + 4 * (i - 1)));
                else n_pass++;
            end
        end
        exp_count += 32'd4;
        n_checks++; if (decoded_count !== exp_count) $display("FAIL b2b_count got %0d exp %0d", decoded_count, exp_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        bit acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_pc        = 32'(32'h400 + 4 * idx);
            in_insn      = 32'(32'h30 | ((idx + 5) << 8));
            in_exec_mask = {32'hA5A5_A5A5, 32'(idx)};
            acc = in_ready && in_valid;
            tick();
            if (acc) idx++;
            if (idx == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++; if (idx !== 3) $display("FAIL bp_accepts got %0d exp 3", idx); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_rd !== 4'd5)
            $display("FAIL bp_hold0 got v %b pc %h rd %h exp v 1 pc 400 rd 5", out_valid, out_pc, out_rd); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_pc !== 32'h404 || out_rd !== 4'd6 || out_exec_mask !== 64'hA5A5_A5A5_0000_0001)
            $display("FAIL bp_pkt1 got pc %h rd %h mask %h", out_pc, out_rd, out_exec_mask); else n_pass++;
        tick();
        n_checks++; if (out_pc !== 32'h408 || out_rd !== 4'd7 || out_exec_mask !== 64'hA5A5_A5A5_0000_0002)
            $display("FAIL bp_pkt2 got pc %h rd %h mask %h", out_pc, out_rd, out_exec_mask); else n_pass++;
        tick();
        exp_count += 32'd3;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (decoded_count !== exp_count) $display("FAIL bp_count got %0d exp %0d", decoded_count, exp_count); else n_pass++;
    endtask

    task automatic test_illegal();
        bit ok;
        int bad = 0;
        out_ready = 1'b1;
        send(64'h3, 32'h200, 32'h0000_00EE, ok);
        tick();
        n_checks++; if (out_class !== 3'd7) $display("FAIL ill_class got %0d exp 7", out_class); else n_pass++;
        n_checks++; if (out_opcode !== 8'hEE) $display("FAIL ill_opcode got %h exp ee", out_opcode); else n_pass++;
        n_checks++; if (illegal_seen !== 1'b1) $display("FAIL ill_seen got %b exp 1", illegal_seen); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10);
            in_pc    = 32'(32'h600 + 4 * i);
            in_insn  = 32'h0000_0030;
            tick();
            if (illegal_seen !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        exp_count += 32'd11;
        n_checks++; if (bad !== 0) $display("FAIL ill_sticky got %0d drops exp 0", bad); else n_pass++;
        n_checks++; if (decoded_count !== exp_count) $display("FAIL ill_count got %0d exp %0d", decoded_count, exp_count); else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] insns [3] = '{32'h0000_00FF, 32'h0000_0030, 32'h0000_0030};
        int idx = 0;
        int bad = 0;
        bit acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_pc   = 32'(32'h500 + 4 * idx);
            in_insn = insns[idx];
            acc = in_ready && in_valid;
            tick();
            if (acc) idx++;
            if (idx == 3) begin
                in_valid = 1'b0;
                idx      = 2;
            end
        end
        n_checks++; if (idx !== 2) $display("FAIL halt_accepts got %0d exp 2", idx); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp 1", halted); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_class !== 3'd4 || out_pc !== 32'h500 || out_flow_change !== 1'b1)
            $display("FAIL halt_pkt got v %b cls %0d pc %h flow %b", out_valid, out_class, out_pc, out_flow_change); else n_pass++;
        in_valid  = 1'b1;
        in_insn   = 32'h0000_0030;
        out_ready = 1'b1;
        tick();
        exp_count += 32'd1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) bad++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL halt_hold got %0d bad cycles exp 0", bad); else n_pass++;
        n_checks++; if (decoded_count !== exp_count) $display("FAIL halt_count got %0d exp %0d", decoded_count, exp_count); else n_pass++;
        reset_n = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL hrst_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (halted !== 1'b0 || illegal_seen !== 1'b0 || decoded_count !== 32'd0)
            $display("FAIL hrst_status got h %b ill %b cnt %0d exp 0 0 0", halted, illegal_seen, decoded_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_exec_mask !== 64'd0 || out_class !== 3'd0 ||
                        out_opcode !== 8'd0 || out_imm !== 32'd0 || out_branch_target !== 32'd0 || out_flow_change !== 1'b0)
            $display("FAIL hrst_outputs got v %b pc %h cls %0d op %h", out_valid, out_pc, out_class, out_opcode); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL hrst_release got %b exp 1", in_ready); else n_pass++;
        exp_count = 32'd0;
        tick();
    endtask

    task automatic test_wrap_and_reset();
        bit ok;
        out_ready = 1'b1;
        force dut.decoded_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.decoded_count_q;
        #1;
        n_checks++; if (decoded_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got %h exp ffffffff", decoded_count); else n_pass++;
        send(64'h4, 32'h700, 32'h0000_0030, ok);
        tick();
        tick();
        n_checks++; if (decoded_count !== 32'd0) $display("FAIL wrap_zero got %h exp 0", decoded_count); else n_pass++;
        out_ready = 1'b0;
        send(64'h5, 32'h704, 32'h0000_0030, ok);
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mrst_pre got %b exp 1", out_valid); else n_pass++;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || decoded_count !== 32'd0)
            $display("FAIL mrst_clear got v %b cnt %0d exp 0 0", out_valid, decoded_count); else n_pass++;
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0 || decoded_count !== 32'd0)
            $display("FAIL mrst_after got v %b cnt %0d exp 0 0", out_valid, decoded_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_class_table();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_halt();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
